// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the PCSrc encodings, the nop word and the buffered entry layout.
package fetch_pkg;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Registered FIFO of fetched {pc, instr} entries.
// Flush wins over push and pop; a push into a full FIFO is allowed alongside a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           full;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wptr <= wptr + AW'(1);
            if (do_pop)
                rptr <= rptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wptr] <= wdata;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential fetch front end: owns the fetch PC, tracks in-flight reads,
// buffers returned words and redirects on taken branch/jalr pops.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic          fifo_empty;
    fetch_entry_t  head;
    fetch_entry_t  wentry;
    logic          pop;
    logic          redirect;
    logic          fire;
    logic          accept;
    logic [31:0]   target;

    assign pop = instr_valid && instr_ready;

    always_comb begin
        redirect = 1'b0;
        target   = branch_target;
        unique case (1'b1)
            pop && (PCSrc == PCSRC_BRANCH): begin
                redirect = 1'b1;
                target   = branch_target;
            end
            pop && (PCSrc == PCSRC_JALR): begin
                redirect = 1'b1;
                target   = {jalr_target[31:1], 1'b0};
            end
            default: ;
        endcase
    end

    // Count buffered plus outstanding words so every response has a slot.
    assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
    assign imem_req  = rst_n && !redirect && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;
    assign fire      = imem_req && imem_gnt;
    assign accept    = imem_rvalid && !redirect && (discard_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            inflight    <= '0;
            discard_cnt <= '0;
        end else begin
            inflight <= inflight + CW'(fire) - CW'(imem_rvalid);
            if (redirect) begin
                fetch_pc    <= target;
                resp_pc     <= target;
                discard_cnt <= inflight - CW'(imem_rvalid);
            end else begin
                if (fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (accept)
                    resp_pc <= resp_pc + 32'd4;
                if (imem_rvalid && (discard_cnt != '0))
                    discard_cnt <= discard_cnt - CW'(1);
            end
        end
    end

    assign wentry = '{pc: resp_pc, instr: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (pop),
        .flush (redirect),
        .wdata (wentry),
        .rdata (head),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign Instr       = fifo_empty ? INSTR_NOP : head.instr;
    assign instr_pc    = fifo_empty ? 32'h0 : head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: stream, backpressure, redirects,
// random-latency redirect stress and a PC-wrap instance with async reset.
module tb_instr_fetch_unit;
    import fetch_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        ivalid;
    logic        ready;
    logic [1:0]  pcsrc;
    logic [31:0] btgt;
    logic [31:0] jtgt;

    logic        rst_nw;
    logic        req_w;
    logic [31:0] addr_w;
    logic        gnt_w;
    logic        rvalid_w;
    logic [31:0] rdata_w;
    logic [31:0] instr_w;
    logic [31:0] ipc_w;
    logic        ivalid_w;
    logic        ready_w;
    logic [1:0]  pcsrc_w;
    logic [31:0] btgt_w;
    logic [31:0] jtgt_w;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [31:0] a;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [1:0]  src;
        logic [31:0] bt;
        logic [31:0] jt;
        logic        rv;
    } pe_t;

    mreq_t       mq[$];
    logic [31:0] glog[$];
    pe_t         plog[$];
    logic [31:0] glog_w[$];
    logic [31:0] plog_w[$];

    bit   rand_mode = 0;
    int   lat = 0;
    int   mem_d;
    logic gnt_en;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (req),
        .imem_addr     (addr),
        .imem_gnt      (gnt),
        .imem_rvalid   (rvalid),
        .imem_rdata    (rdata),
        .Instr         (instr),
        .instr_pc      (ipc),
        .instr_valid   (ivalid),
        .instr_ready   (ready),
        .PCSrc         (pcsrc),
        .branch_target (btgt),
        .jalr_target   (jtgt)
    );

    instr_fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8),
        .DEPTH    (2)
    ) dut_w (
        .clk           (clk),
        .rst_n         (rst_nw),
        .imem_req      (req_w),
        .imem_addr     (addr_w),
        .imem_gnt      (gnt_w),
        .imem_rvalid   (rvalid_w),
        .imem_rdata    (rdata_w),
        .Instr         (instr_w),
        .instr_pc      (ipc_w),
        .instr_valid   (ivalid_w),
        .instr_ready   (ready_w),
        .PCSrc         (pcsrc_w),
        .branch_target (btgt_w),
        .jalr_target   (jtgt_w)
    );

    function automatic logic [31:0] mk(input logic [31:0] a);
        return a ^ 32'h5EED_0003;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end

    always @(posedge clk) cyc <= cyc + 1;

    assign gnt     = req && gnt_en;
    assign gnt_w   = req_w;
    assign ready_w = 1'b1;
    assign pcsrc_w = PCSRC_SEQ;
    assign btgt_w  = 32'h0;
    assign jtgt_w  = 32'h0;

    // In-order memory: grant gated by gnt_en, response after lat/random delay.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            rvalid <= 1'b0;
            rdata  <= 32'h0;
            gnt_en <= 1'b1;
        end else begin
            if (req && gnt) begin
                mem_d = rand_mode ? int'($urandom_range(0, 3)) : lat;
                mq.push_back('{addr, cyc + mem_d});
                glog.push_back(addr);
            end
            rvalid <= 1'b0;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                rvalid <= 1'b1;
                rdata  <= mk(mq[0].a);
                void'(mq.pop_front());
            end
            gnt_en <= rand_mode ? ($urandom_range(0, 3) == 0) : 1'b1;
        end
    end

    always @(posedge clk)
        if (rst_n && ivalid && ready)
            plog.push_back('{ipc, instr, pcsrc, btgt, jtgt, rvalid});

    always @(posedge clk or negedge rst_nw) begin
        if (!rst_nw) begin
            rvalid_w <= 1'b0;
            rdata_w  <= 32'h0;
        end else begin
            rvalid_w <= req_w;
            rdata_w  <= mk(addr_w);
            if (req_w)
                glog_w.push_back(addr_w);
            if (ivalid_w)
                plog_w.push_back(ipc_w);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gpc(input int i);
        return (i < plog.size()) ? plog[i].pc : 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] gad(input int i);
        return (i < glog.size()) ? glog[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        ready = 1'b0;
        pcsrc = PCSRC_SEQ;
        repeat (2) @(negedge clk);
        glog.delete();
        plog.delete();
    endtask

    initial begin
        logic [31:0] exp_pc;
        int          k;
        int          rvr;
        bit          found;

        rst_n  = 1'b0;
        rst_nw = 1'b0;
        ready  = 1'b0;
        pcsrc  = PCSRC_SEQ;
        btgt   = 32'h0;
        jtgt   = 32'h0;
        repeat (3) @(negedge clk);

        chk("rst_req", req, 1'b0);
        chk("rst_addr", addr, 32'h0);
        chk("rst_instr", instr, INSTR_NOP);
        chk("rst_pc", ipc, 32'h0);
        chk("rst_valid", ivalid, 1'b0);
        chk("rst_addr_w", addr_w, 32'hFFFF_FFF8);

        // zero-wait stream
        glog.delete();
        plog.delete();
        ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("c0_req", req, 1'b1);
        chk("c0_addr", addr, 32'h0);
        @(negedge clk);
        chk("c1_valid", ivalid, 1'b0);
        @(negedge clk);
        chk("c2_valid", ivalid, 1'b1);
        chk("c2_pc", ipc, 32'h0);
        chk("c2_instr", instr, mk(32'h0));
        @(negedge clk);
        chk("c3_pc", ipc, 32'h4);
        @(negedge clk);
        chk("c4_pc", ipc, 32'h8);
        chk("c4_instr", instr, mk(32'h8));
        repeat (4) @(negedge clk);
        chk("s_g0", gad(0), 32'h0);
        chk("s_g1", gad(1), 32'h4);
        chk("s_g2", gad(2), 32'h8);

        // backpressure
        do_reset();
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("bp_grants", glog.size(), 4);
        chk("bp_req", req, 1'b0);
        chk("bp_valid", ivalid, 1'b1);
        chk("bp_pc", ipc, 32'h0);
        chk("bp_instr", instr, mk(32'h0));
        ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("bp_p0", gpc(0), 32'h0);
        chk("bp_p1", gpc(1), 32'h4);
        chk("bp_p2", gpc(2), 32'h8);
        chk("bp_p3", gpc(3), 32'hC);

        // branch with two requests in flight
        do_reset();
        lat = 1;
        ready = 1'b1;
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (ivalid && ipc == 32'h8)
                found = 1'b1;
        end
        chk("br_found", found, 1'b1);
        chk("br_inflight", 32'(dut.inflight), 32'd2);
        pcsrc = PCSRC_BRANCH;
        btgt  = 32'h40;
        #1;
        chk("br_req_retract", req, 1'b0);
        @(negedge clk);
        pcsrc = PCSRC_SEQ;
        chk("br_req", req, 1'b1);
        chk("br_addr", addr, 32'h40);
        chk("br_valid_n1", ivalid, 1'b0);
        repeat (8) @(negedge clk);
        chk("br_p2", gpc(2), 32'h8);
        chk("br_p3", gpc(3), 32'h40);
        chk("br_i3", (plog.size() > 3) ? plog[3].ins : 32'hx, mk(32'h40));
        chk("br_p4", gpc(4), 32'h44);
        found = 1'b0;
        foreach (plog[i])
            if (plog[i].pc == 32'hC || plog[i].pc == 32'h10)
                found = 1'b1;
        chk("br_no_stale", found, 1'b0);

        // jalr clears the target LSB
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (ivalid)
                found = 1'b1;
            else
                @(negedge clk);
        end
        chk("jr_found", found, 1'b1);
        k = plog.size();
        pcsrc = PCSRC_JALR;
        jtgt  = 32'h123;
        @(negedge clk);
        pcsrc = PCSRC_SEQ;
        chk("jr_req", req, 1'b1);
        chk("jr_addr", addr, 32'h122);
        repeat (8) @(negedge clk);
        chk("jr_next", gpc(k + 1), 32'h122);
        chk("jr_instr", (plog.size() > k + 1) ? plog[k + 1].ins : 32'hx,
            mk(32'h122));

        // random latency with redirects, many on rvalid cycles
        do_reset();
        lat = 0;
        rand_mode = 1;
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            ready = ($urandom_range(0, 3) != 0);
            pcsrc = PCSRC_SEQ;
            btgt  = $urandom_range(0, 2047);
            jtgt  = $urandom;
            if (ivalid && (rvalid || $urandom_range(0, 3) == 0)
                && $urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 2))
                    0:       pcsrc = PCSRC_BRANCH;
                    1:       pcsrc = PCSRC_JALR;
                    default: pcsrc = 2'b11;
                endcase
            end
        end
        pcsrc = PCSRC_SEQ;
        ready = 1'b0;
        repeat (40) @(negedge clk);
        chk("rnd_inflight", 32'(dut.inflight), 32'd0);
        chk("rnd_discard", 32'(dut.discard_cnt), 32'd0);
        exp_pc = 32'h0;
        rvr = 0;
        foreach (plog[i]) begin
            chk("rnd_pc", plog[i].pc, exp_pc);
            chk("rnd_instr", plog[i].ins, mk(exp_pc));
            case (plog[i].src)
                PCSRC_BRANCH: exp_pc = plog[i].bt;
                PCSRC_JALR:   exp_pc = {plog[i].jt[31:1], 1'b0};
                default:      exp_pc = exp_pc + 32'd4;
            endcase
            if (plog[i].rv && (plog[i].src == PCSRC_BRANCH
                               || plog[i].src == PCSRC_JALR))
                rvr++;
        end
        chk("rnd_pops", (plog.size() > 50), 1'b1);
        chk("rnd_rv_redirects", (rvr > 0), 1'b1);
        rand_mode = 0;

        // PC wrap and asynchronous mid-stream reset
        glog_w.delete();
        plog_w.delete();
        rst_nw = 1'b1;
        #1;
        chk("w_req", req_w, 1'b1);
        chk("w_addr", addr_w, 32'hFFFF_FFF8);
        repeat (6) @(negedge clk);
        chk("w_g0", (glog_w.size() > 0) ? glog_w[0] : 32'hx, 32'hFFFF_FFF8);
        chk("w_g1", (glog_w.size() > 1) ? glog_w[1] : 32'hx, 32'hFFFF_FFFC);
        chk("w_g2", (glog_w.size() > 2) ? glog_w[2] : 32'hx, 32'h0);
        chk("w_p0", (plog_w.size() > 0) ? plog_w[0] : 32'hx, 32'hFFFF_FFF8);
        chk("w_p1", (plog_w.size() > 1) ? plog_w[1] : 32'hx, 32'hFFFF_FFFC);
        chk("w_p2", (plog_w.size() > 2) ? plog_w[2] : 32'hx, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (ivalid_w)
                found = 1'b1;
            else
                @(negedge clk);
        end
        chk("w_valid_pre", found, 1'b1);
        rst_nw = 1'b0;
        #1;
        chk("w_async_valid", ivalid_w, 1'b0);
        chk("w_async_req", req_w, 1'b0);
        chk("w_async_instr", instr_w, INSTR_NOP);
        chk("w_async_addr", addr_w, 32'hFFFF_FFF8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
